muldiv_unit: RTL

//   Iterative multiply/divide unit owning the HI/LO register pair of the datapath.

---
 rtl/muldiv_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit that owns the HI/LO register pair.
// Shift-add multiply and restoring divide, WIDTH iterations plus a sign-fix cycle.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [2:0] OP_MTHI = 3'b100;
   localparam logic [2:0] OP_MTLO = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX
   } state_t;

   state_t                 r_state;
   logic [CW-1:0]          r_cnt;
   logic [2*WIDTH-1:0]     r_acc;
   logic [WIDTH-1:0]       r_d;
   logic [WIDTH-1:0]       r_a;
   logic                   r_div;
   logic                   r_negq;
   logic                   r_negr;
   logic                   r_dz;
   logic [WIDTH-1:0]       r_hi;
   logic [WIDTH-1:0]       r_lo;
   logic                   r_busy;
   logic                   r_done;

   logic                   w_accept;
   logic                   w_sgn;
   logic [WIDTH-1:0]       w_mag_a;
   logic [WIDTH-1:0]       w_mag_b;
   logic [WIDTH:0]         w_madd;
   logic [2*WIDTH-1:0]     w_mul_nxt;
   logic [WIDTH:0]         w_shl;
   logic [WIDTH:0]         w_sub;
   logic                   w_ge;
   logic [2*WIDTH-1:0]     w_div_nxt;
   logic [2*WIDTH-1:0]     w_prod;
   logic [WIDTH-1:0]       w_quo;
   logic [WIDTH-1:0]       w_rem;

   assign w_accept = start && (r_state == S_IDLE);
   assign w_sgn    = op[0];
   assign w_mag_a  = (w_sgn && a[WIDTH-1]) ? -a : a;
   assign w_mag_b  = (w_sgn && b[WIDTH-1]) ? -b : b;

   // Multiply: low half holds the multiplier, consumed LSB first.
   assign w_madd    = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                    + (r_acc[0] ? {1'b0, r_d} : '0);
   assign w_mul_nxt = {w_madd, r_acc[WIDTH-1:1]};

   // Divide: upper half is the partial remainder, lower half the quotient.
   assign w_shl     = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
   assign w_sub     = w_shl - {1'b0, r_d};
   assign w_ge      = ~w_sub[WIDTH];
   assign w_div_nxt = {w_ge ? w_sub[WIDTH-1:0] : w_shl[WIDTH-1:0],
                       r_acc[WIDTH-2:0], w_ge};

   assign w_prod = r_negq ? -r_acc : r_acc;
   assign w_quo  = r_negq ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
   assign w_rem  = r_negr ? -r_acc[2*WIDTH-1:WIDTH]
                          : r_acc[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_d     <= '0;
         r_a     <= '0;
         r_div   <= 1'b0;
         r_negq  <= 1'b0;
         r_negr  <= 1'b0;
         r_dz    <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (!op[2]) begin
                     r_state <= S_CALC;
                     r_cnt   <= '0;
                     r_busy  <= 1'b1;
                     r_div   <= op[1];
                     r_a     <= a;
                     r_negq  <= w_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                     r_negr  <= w_sgn & a[WIDTH-1];
                     r_dz    <= op[1] && (b == '0);
                     if (op[1]) begin
                        r_acc <= {{WIDTH{1'b0}}, w_mag_a};
                        r_d   <= w_mag_b;
                     end else begin
                        r_acc <= {{WIDTH{1'b0}}, w_mag_b};
                        r_d   <= w_mag_a;
                     end
                  end else if (op == OP_MTHI) begin
                     r_hi <= a;
                  end else if (op == OP_MTLO) begin
                     r_lo <= a;
                  end
               end
            end
            S_CALC: begin
               r_acc <= r_div ? w_div_nxt : w_mul_nxt;
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == LAST) r_state <= S_FIX;
            end
            S_FIX: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               if (!r_div) begin
                  r_hi <= w_prod[2*WIDTH-1:WIDTH];
                  r_lo <= w_prod[WIDTH-1:0];
               end else if (r_dz) begin
                  // Divide by zero reports the raw dividend, not its magnitude.
                  r_hi <= r_a;
                  r_lo <= '1;
               end else begin
                  r_hi <= w_rem;
                  r_lo <= w_quo;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign hi   = r_hi;
   assign lo   = r_lo;
   assign busy = r_busy;
   assign done = r_done;

endmodule
